// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and transfer status bundle for ps2_host_tx
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       ack_ok;
  logic       err_noack;
  logic       err_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, done, ack_ok, err_noack, err_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, done, ack_ok, err_noack, err_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (open-collector pin drive)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int FRAME_TIMEOUT  = 200000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  output logic          rx_inhibit
);

  localparam int MAXP = (INHIBIT_CYCLES > START_TIMEOUT)
                        ? ((INHIBIT_CYCLES > FRAME_TIMEOUT) ? INHIBIT_CYCLES : FRAME_TIMEOUT)
                        : ((START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT);
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] INH_END  = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_TO = CW'(START_TIMEOUT);
  localparam logic [CW-1:0] FRAME_TO = CW'(FRAME_TIMEOUT);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, WAIT_IDLE, ERR, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    sh;
  logic          nack;
  logic          clk_meta, clk_s, clk_prev;
  logic          data_meta, data_s;
  logic          fall;
  logic [CW-1:0] frame_next;

  assign fall = clk_prev & ~clk_s;
  // Saturate so an edge landing exactly on the limit can never wrap the frame timer.
  assign frame_next = (cnt == FRAME_TO) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      sh               <= '0;
      nack             <= 1'b0;
      clk_meta         <= 1'b1;
      clk_s            <= 1'b1;
      clk_prev         <= 1'b1;
      data_meta        <= 1'b1;
      data_s           <= 1'b1;
      ps2_clk_oe       <= 1'b0;
      ps2_data_oe      <= 1'b0;
      rx_inhibit       <= 1'b0;
      host.tx_ready    <= 1'b1;
      host.done        <= 1'b0;
      host.ack_ok      <= 1'b0;
      host.err_noack   <= 1'b0;
      host.err_timeout <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_s     <= clk_meta;
      clk_prev  <= clk_s;
      data_meta <= ps2_data_in;
      data_s    <= data_meta;

      case (state)
        IDLE: begin
          if (host.tx_valid) begin
            sh            <= {1'b1, ~^host.tx_data, host.tx_data};
            cnt           <= '0;
            ps2_clk_oe    <= 1'b1;
            ps2_data_oe   <= 1'b0;
            rx_inhibit    <= 1'b1;
            host.tx_ready <= 1'b0;
            state         <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Start bit goes low one cycle before the clock is released.
          if (cnt == INH_END) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= REQ;
          end else begin
            if (cnt == INH_LAST) ps2_data_oe <= 1'b1;
            cnt <= cnt + CW'(1);
          end
        end
        REQ: begin
          if (fall) begin
            bit_idx     <= '0;
            ps2_data_oe <= ~sh[0];
            cnt         <= '0;
            state       <= DATA;
          end else if (cnt == START_TO) begin
            ps2_data_oe <= 1'b0;
            state       <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (fall) begin
            cnt <= frame_next;
            if (bit_idx == 4'd9) begin
              nack        <= data_s;
              ps2_data_oe <= 1'b0;
              state       <= WAIT_IDLE;
            end else begin
              bit_idx     <= bit_idx + 4'd1;
              ps2_data_oe <= ~sh[bit_idx + 4'd1];
            end
          end else if (cnt == FRAME_TO) begin
            ps2_data_oe <= 1'b0;
            state       <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            host.done      <= 1'b1;
            host.ack_ok    <= ~nack;
            host.err_noack <= nack;
            state          <= DONE;
          end else if (cnt == FRAME_TO) begin
            state <= ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ERR: begin
          ps2_clk_oe       <= 1'b0;
          ps2_data_oe      <= 1'b0;
          host.done        <= 1'b1;
          host.err_timeout <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          host.done        <= 1'b0;
          host.ack_ok      <= 1'b0;
          host.err_noack   <= 1'b0;
          host.err_timeout <= 1'b0;
          host.tx_ready    <= 1'b1;
          rx_inhibit       <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
